// File: rtl/lwc_api_pkg.sv
// ============================================================================
// Module      : lwc_api_pkg
// Description : LWC-API opcodes, segment types, header field positions,
//               pre-processor FSM states and bdi byte-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lwc_api_pkg;

    localparam logic [3:0] OP_ACTKEY = 4'b0111;
    localparam logic [3:0] OP_ENC    = 4'b0010;
    localparam logic [3:0] OP_DEC    = 4'b0011;
    localparam logic [3:0] OP_LDKEY  = 4'b0100;

    localparam logic [3:0] HT_AD     = 4'b0001;
    localparam logic [3:0] HT_PT     = 4'b0100;
    localparam logic [3:0] HT_CT     = 4'b0101;
    localparam logic [3:0] HT_TAG    = 4'b1000;
    localparam logic [3:0] HT_KEY    = 4'b1100;
    localparam logic [3:0] HT_NPUB   = 4'b1101;

    localparam int HDR_OP_MSB  = 31;
    localparam int HDR_OP_LSB  = 28;
    localparam int HDR_EOI     = 26;
    localparam int HDR_EOT     = 25;
    localparam int HDR_LAST    = 24;
    localparam int HDR_LEN_MSB = 15;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SDI_INSTR = 4'd1,
        ST_SDI_HDR   = 4'd2,
        ST_LD_KEY    = 4'd3,
        ST_NPUB_HDR  = 4'd4,
        ST_LD_NPUB   = 4'd5,
        ST_DATA_HDR  = 4'd6,
        ST_LD_DATA   = 4'd7,
        ST_TAG_HDR   = 4'd8,
        ST_LD_TAG    = 4'd9
    } state_t;

    // Big-endian: byte 0 is [31:24], so a short word keeps its upper bytes.
    function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [2:0] size);
        logic [31:0] m;
        case (size)
            3'd1:    m = 32'hFF00_0000;
            3'd2:    m = 32'hFFFF_0000;
            3'd3:    m = 32'hFFFF_FF00;
            3'd4:    m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return d & m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_len_counter.sv
// ============================================================================
// Module      : seg_len_counter
// Description : Remaining-length tracker for one data segment; reports the
//               byte count, last and partial flags of the current word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_len_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] len_i,
    input  logic        dec_i,
    output logic [2:0]  size_o,
    output logic        last_o,
    output logic        partial_o
);

    logic [15:0] rem_q;
    logic [15:0] rem_d;

    assign size_o    = (rem_q >= 16'd4) ? 3'd4 : {1'b0, rem_q[1:0]};
    assign last_o    = (rem_q <= 16'd4);
    assign partial_o = (size_o != 3'd4);

    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = len_i;
        end else if (dec_i) begin
            rem_d = rem_q - {13'd0, size_o};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= 16'd0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pre_processor.sv
// ============================================================================
// Module      : pre_processor
// Description : LWC-API header parser feeding key/bdi words to the controller
//               and forwarding instructions / PT-CT headers on cmd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pre_processor
    import lwc_api_pkg::*;
#(
    parameter int W          = 32,
    parameter int KEY_WORDS  = 4,
    parameter int NPUB_WORDS = 4,
    parameter int TAG_WORDS  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pdi_data,
    input  logic         pdi_valid,
    output logic         pdi_ready,
    input  logic [W-1:0] sdi_data,
    input  logic         sdi_valid,
    output logic         sdi_ready,
    output logic [W-1:0] key,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         key_update,
    output logic [W-1:0] bdi,
    output logic         bdi_valid,
    input  logic         bdi_ready,
    output logic [3:0]   bdi_type,
    output logic         bdi_eot,
    output logic         bdi_eoi,
    output logic [2:0]   bdi_size,
    output logic         bdi_partial,
    output logic         decrypt,
    output logic [W-1:0] cmd_data,
    output logic         cmd_valid,
    input  logic         cmd_ready
);

    state_t     state_q, state_d;
    logic [1:0] ctr_q, ctr_d;
    logic       decrypt_q, decrypt_d;
    logic       eot_q, eot_d;
    logic       eoi_q, eoi_d;
    logic [3:0] type_q, type_d;

    logic [3:0] w_pdi_op;
    logic [3:0] w_sdi_op;
    logic [2:0] w_seg_size;
    logic       w_seg_last;
    logic       w_seg_partial;
    logic       w_pdi_hs;
    logic       w_sdi_hs;
    logic       w_cmd_hdr;
    state_t     w_seg_end_state;
    state_t     w_zero_len_state;

    assign w_pdi_op = pdi_data[HDR_OP_MSB:HDR_OP_LSB];
    assign w_sdi_op = sdi_data[HDR_OP_MSB:HDR_OP_LSB];
    assign w_pdi_hs = pdi_valid & pdi_ready;
    assign w_sdi_hs = sdi_valid & sdi_ready;
    assign w_cmd_hdr = (state_q == ST_IDLE)
                     ? ((w_pdi_op == OP_ENC) || (w_pdi_op == OP_DEC))
                     : ((w_pdi_op == HT_PT) || (w_pdi_op == HT_CT));

    assign w_seg_end_state  = eoi_q ? (decrypt_q ? ST_TAG_HDR : ST_IDLE) : ST_DATA_HDR;
    assign w_zero_len_state = pdi_data[HDR_EOI] ? (decrypt_q ? ST_TAG_HDR : ST_IDLE) : ST_DATA_HDR;

    seg_len_counter u_seg_len_counter (
        .clk       (clk),
        .rst       (rst),
        .load_i    ((state_q == ST_DATA_HDR) && w_pdi_hs),
        .len_i     (pdi_data[HDR_LEN_MSB:0]),
        .dec_i     ((state_q == ST_LD_DATA) && w_pdi_hs),
        .size_o    (w_seg_size),
        .last_o    (w_seg_last),
        .partial_o (w_seg_partial)
    );

    // Handshake and bdi muxing: data words are combinational pass-throughs.
    always_comb begin
        pdi_ready   = 1'b0;
        sdi_ready   = 1'b0;
        key_valid   = 1'b0;
        key_update  = 1'b0;
        bdi_valid   = 1'b0;
        bdi_type    = 4'd0;
        bdi_eot     = 1'b0;
        bdi_eoi     = 1'b0;
        bdi_size    = 3'd0;
        bdi_partial = 1'b0;
        cmd_valid   = 1'b0;
        key         = sdi_data;
        cmd_data    = pdi_data;
        case (state_q)
            ST_IDLE, ST_DATA_HDR: begin
                if (pdi_valid) begin
                    if (w_cmd_hdr) begin
                        cmd_valid = 1'b1;
                        pdi_ready = cmd_ready;
                    end else begin
                        pdi_ready = 1'b1;
                    end
                end
            end
            ST_SDI_INSTR, ST_SDI_HDR: begin
                sdi_ready = sdi_valid;
            end
            ST_LD_KEY: begin
                key_valid  = sdi_valid;
                sdi_ready  = key_ready;
                key_update = 1'b1;
            end
            ST_NPUB_HDR, ST_TAG_HDR: begin
                pdi_ready = pdi_valid;
            end
            ST_LD_NPUB: begin
                bdi_valid = pdi_valid;
                pdi_ready = bdi_ready;
                bdi_type  = HT_NPUB;
                bdi_size  = 3'd4;
                if (ctr_q == 2'(NPUB_WORDS - 1)) begin
                    bdi_eot = eot_q;
                    bdi_eoi = eoi_q;
                end
            end
            ST_LD_DATA: begin
                bdi_valid   = pdi_valid;
                pdi_ready   = bdi_ready;
                bdi_type    = type_q;
                bdi_size    = w_seg_size;
                bdi_partial = w_seg_partial;
                if (w_seg_last) begin
                    bdi_eot = eot_q;
                    bdi_eoi = eoi_q;
                end
            end
            ST_LD_TAG: begin
                bdi_valid = pdi_valid;
                pdi_ready = bdi_ready;
                bdi_type  = HT_TAG;
                bdi_size  = 3'd4;
            end
            default: ;
        endcase
        bdi = mask_bytes(pdi_data, bdi_size);
    end

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        decrypt_d = decrypt_q;
        eot_d     = eot_q;
        eoi_d     = eoi_q;
        type_d    = type_q;
        case (state_q)
            ST_IDLE: begin
                if (w_pdi_hs) begin
                    if (w_pdi_op == OP_ACTKEY) begin
                        state_d = ST_SDI_INSTR;
                    end else if (w_cmd_hdr) begin
                        decrypt_d = (w_pdi_op == OP_DEC);
                        state_d   = ST_NPUB_HDR;
                    end
                end
            end
            ST_SDI_INSTR: begin
                if (w_sdi_hs && (w_sdi_op == OP_LDKEY)) state_d = ST_SDI_HDR;
            end
            ST_SDI_HDR: begin
                if (w_sdi_hs) begin
                    ctr_d   = 2'd0;
                    state_d = ST_LD_KEY;
                end
            end
            ST_LD_KEY: begin
                if (w_sdi_hs) begin
                    if (ctr_q == 2'(KEY_WORDS - 1)) begin
                        ctr_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        ctr_d = ctr_q + 2'd1;
                    end
                end
            end
            ST_NPUB_HDR: begin
                if (w_pdi_hs) begin
                    eot_d   = pdi_data[HDR_EOT];
                    eoi_d   = pdi_data[HDR_EOI];
                    ctr_d   = 2'd0;
                    state_d = ST_LD_NPUB;
                end
            end
            ST_LD_NPUB: begin
                if (w_pdi_hs) begin
                    if (ctr_q == 2'(NPUB_WORDS - 1)) begin
                        ctr_d   = 2'd0;
                        state_d = w_seg_end_state;
                    end else begin
                        ctr_d = ctr_q + 2'd1;
                    end
                end
            end
            ST_DATA_HDR: begin
                if (w_pdi_hs) begin
                    type_d  = w_pdi_op;
                    eot_d   = pdi_data[HDR_EOT];
                    eoi_d   = pdi_data[HDR_EOI];
                    state_d = (pdi_data[HDR_LEN_MSB:0] == 16'd0) ? w_zero_len_state : ST_LD_DATA;
                end
            end
            ST_LD_DATA: begin
                if (w_pdi_hs && w_seg_last) state_d = w_seg_end_state;
            end
            ST_TAG_HDR: begin
                if (w_pdi_hs) begin
                    ctr_d   = 2'd0;
                    state_d = ST_LD_TAG;
                end
            end
            ST_LD_TAG: begin
                if (w_pdi_hs) begin
                    if (ctr_q == 2'(TAG_WORDS - 1)) begin
                        ctr_d   = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        ctr_d = ctr_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ctr_q     <= 2'd0;
            decrypt_q <= 1'b0;
            eot_q     <= 1'b0;
            eoi_q     <= 1'b0;
            type_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            decrypt_q <= decrypt_d;
            eot_q     <= eot_d;
            eoi_q     <= eoi_d;
            type_q    <= type_d;
        end
    end

    assign decrypt = decrypt_q;

endmodule

`default_nettype wire
